// File: rtl/pool2_pkg.sv
// Shared defaults and derived sizes for the 2x2/stride-2 max-pool stage.
package pool2_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_IMG_W  = 8;
    localparam int unsigned DEF_IMG_H  = 8;
    localparam int unsigned DEF_OUT_W  = DEF_IMG_W / 2;
    localparam int unsigned DEF_OUT_H  = DEF_IMG_H / 2;
    localparam int unsigned DEF_COL_W  = $clog2(DEF_IMG_W);
    localparam int unsigned DEF_ROW_W  = $clog2(DEF_IMG_H);

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool2_channel.sv
// One channel of the max-pool datapath: horizontal pair max, line buffer of
// even-row pair maxima, and the final vertical max into the output register.
module pool2_channel
    import pool2_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned BUF_N  = DEF_OUT_W,
    parameter int unsigned IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] pixel,
    input  logic              is_odd_col,
    input  logic              is_odd_row,
    input  logic [IDX_W-1:0]  buf_idx,
    output logic [DATA_W-1:0] pooled
);

    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] hmax, vmax, line_rd;
    logic              line_wr_en;
    logic [DATA_W-1:0] line_buf_q [BUF_N];

    assign hmax       = (hold_q > pixel) ? hold_q : pixel;
    assign line_rd    = line_buf_q[buf_idx];
    assign vmax       = (line_rd > hmax) ? line_rd : hmax;
    assign line_wr_en = in_valid & is_odd_col & ~is_odd_row;

    always_comb begin
        hold_d = hold_q;
        out_d  = out_q;
        if (in_valid) begin
            if (!is_odd_col) begin
                hold_d = pixel;
            end else if (is_odd_row) begin
                out_d = vmax;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            out_q  <= '0;
        end else begin
            hold_q <= hold_d;
            out_q  <= out_d;
        end
    end

    // Contents are don't-care after reset: every read on an odd row is
    // preceded by a write to the same entry on the even row above.
    always_ff @(posedge clk) begin
        if (line_wr_en) begin
            line_buf_q[buf_idx] <= hmax;
        end
    end

    assign pooled = out_q;

endmodule

// File: rtl/pool2_layer.sv
// Streaming 2x2/stride-2 max-pool over a 3-channel raster-order feature map;
// owns the shared col/row counters and the out_valid pulse.
module pool2_layer
    import pool2_pkg::*;
#(
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_1,
    output logic [DATA_W-1:0] out_2,
    output logic [DATA_W-1:0] out_3
);

    localparam int unsigned OUT_W = IMG_W / 2;
    localparam int unsigned COL_W = cnt_w(IMG_W);
    localparam int unsigned ROW_W = cnt_w(IMG_H);
    localparam int unsigned IDX_W = cnt_w(OUT_W);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             out_valid_q, out_valid_d;
    logic             is_odd_col, is_odd_row, is_last_col, is_last_row;
    logic [IDX_W-1:0] buf_idx;

    assign is_odd_col  = col_q[0];
    assign is_odd_row  = row_q[0];
    assign is_last_col = (col_q == COL_W'(IMG_W - 1));
    assign is_last_row = (row_q == ROW_W'(IMG_H - 1));
    assign buf_idx     = IDX_W'(col_q >> 1);

    // Frame wrap shares the edge with the last window's pulse, so the next
    // frame's first pixel may follow with no idle cycle.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_valid_d = is_odd_col & is_odd_row;
            if (is_last_col) begin
                col_d = '0;
                row_d = is_last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    pool2_channel #(.DATA_W(DATA_W), .BUF_N(OUT_W), .IDX_W(IDX_W)) u_ch1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .pixel     (in_1),
        .is_odd_col(is_odd_col),
        .is_odd_row(is_odd_row),
        .buf_idx   (buf_idx),
        .pooled    (out_1)
    );

    pool2_channel #(.DATA_W(DATA_W), .BUF_N(OUT_W), .IDX_W(IDX_W)) u_ch2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .pixel     (in_2),
        .is_odd_col(is_odd_col),
        .is_odd_row(is_odd_row),
        .buf_idx   (buf_idx),
        .pooled    (out_2)
    );

    pool2_channel #(.DATA_W(DATA_W), .BUF_N(OUT_W), .IDX_W(IDX_W)) u_ch3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .pixel     (in_3),
        .is_odd_col(is_odd_col),
        .is_odd_row(is_odd_row),
        .buf_idx   (buf_idx),
        .pooled    (out_3)
    );

endmodule

// File: tb/tb_pool2_layer.sv
// Directed and random checks for pool2_layer against hand tables and a
// software 2x2 max model.
module tb_pool2_layer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_1 = '0, in_2 = '0, in_3 = '0;
    logic       out_valid;
    logic [7:0] out_1, out_2, out_3;

    pool2_layer #(.IMG_W(8), .IMG_H(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_1     (in_1),
        .in_2     (in_2),
        .in_3     (in_3),
        .out_valid(out_valid),
        .out_1    (out_1),
        .out_2    (out_2),
        .out_3    (out_3)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned RAMP1 [16] = '{9, 11, 13, 15, 25, 27, 29, 31,
                                41, 43, 45, 47, 57, 59, 61, 63};
    int unsigned RAMP2 [16] = '{255, 253, 251, 249, 239, 237, 235, 233,
                                223, 221, 219, 217, 207, 205, 203, 201};

    logic [7:0]  src1 [8][8], src2 [8][8], src3 [8][8];
    int unsigned m1 [8][8], m2 [8][8], m3 [8][8];
    int          mr = 0, mc = 0;
    bit          last_ov = 0;
    int unsigned pulse_cnt = 0;
    int unsigned got1 [$], got2 [$], got3 [$];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned max4(input int unsigned a, b, c, d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic step(input bit v, input logic [7:0] a, b, c);
        bit          ep;
        int unsigned e1, e2, e3;
        ep = 0; e1 = 0; e2 = 0; e3 = 0;
        in_valid = v; in_1 = a; in_2 = b; in_3 = c;
        if (v) begin
            m1[mr][mc] = a; m2[mr][mc] = b; m3[mr][mc] = c;
            if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                ep = 1;
                e1 = max4(m1[mr-1][mc-1], m1[mr-1][mc], m1[mr][mc-1], m1[mr][mc]);
                e2 = max4(m2[mr-1][mc-1], m2[mr-1][mc], m2[mr][mc-1], m2[mr][mc]);
                e3 = max4(m3[mr-1][mc-1], m3[mr-1][mc], m3[mr][mc-1], m3[mr][mc]);
            end
            if (mc == 7) begin
                mc = 0;
                mr = (mr == 7) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, ep);
        if (ep) begin
            check("out_1", out_1, e1);
            check("out_2", out_2, e2);
            check("out_3", out_3, e3);
        end
        if (out_valid) begin
            check("back_to_back", last_ov, 0);
            got1.push_back(out_1); got2.push_back(out_2); got3.push_back(out_3);
            pulse_cnt++;
        end
        last_ov = out_valid;
    endtask

    task automatic do_reset(input int unsigned cycles);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_out", {out_1, out_2, out_3}, 0);
        for (int unsigned i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check("rst_valid_hold", out_valid, 0);
            check("rst_out_hold", {out_1, out_2, out_3}, 0);
        end
        rst_n = 1'b1;
        mr = 0; mc = 0; last_ov = 0;
    endtask

    // kind: 0 ramp, 1 ramp+64, 2 tie/extreme, 3 random
    task automatic fill(input int kind);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                case (kind)
                    0: begin
                        src1[r][c] = 8'(r * 8 + c);
                        src2[r][c] = 8'(255 - (r * 8 + c));
                        src3[r][c] = 8'd7;
                    end
                    1: begin
                        src1[r][c] = 8'(r * 8 + c + 64);
                        src2[r][c] = 8'(255 - (r * 8 + c));
                        src3[r][c] = 8'd7;
                    end
                    2: begin
                        src1[r][c] = ((r == 0 && c == 0) || (r == 1 && c == 1)) ? 8'd255 : 8'd0;
                        src2[r][c] = 8'd0;
                        src3[r][c] = 8'd128;
                    end
                    default: begin
                        src1[r][c] = 8'($urandom_range(0, 255));
                        src2[r][c] = 8'($urandom_range(0, 255));
                        src3[r][c] = 8'($urandom_range(0, 255));
                    end
                endcase
            end
        end
    endtask

    task automatic feed(input int unsigned gap_pct, input int unsigned n_pix);
        int unsigned k;
        k = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (k < n_pix) begin
                    for (int g = 0; g < 8 && $urandom_range(0, 99) < gap_pct; g++)
                        step(0, 8'($urandom), 8'($urandom), 8'($urandom));
                    step(1, src1[r][c], src2[r][c], src3[r][c]);
                end
                k++;
            end
        end
    endtask

    task automatic clear_got();
        got1.delete(); got2.delete(); got3.delete();
        pulse_cnt = 0;
    endtask

    task automatic check_ramp(input int unsigned base, input int unsigned off, input bit with_ch2);
        for (int unsigned i = 0; i < 16; i++) begin
            if (base + i < got1.size()) begin
                check("ramp_ch1", got1[base+i], (RAMP1[i] + off) % 256);
                if (with_ch2) check("ramp_ch2", got2[base+i], RAMP2[i]);
                check("ramp_ch3", got3[base+i], 7);
            end
        end
    endtask

    initial begin
        do_reset(2);

        // Ramp, continuous valid
        clear_got();
        fill(0);
        feed(0, 64);
        step(0, '0, '0, '0);
        check("ramp_pulses", pulse_cnt, 16);
        check_ramp(0, 0, 1);

        // Ramp with ~40% gaps
        clear_got();
        feed(40, 64);
        step(0, '0, '0, '0);
        check("gap_pulses", pulse_cnt, 16);
        check_ramp(0, 0, 1);

        // Two frames back to back
        clear_got();
        fill(0);
        feed(0, 64);
        fill(1);
        feed(0, 64);
        step(0, '0, '0, '0);
        check("b2b_pulses", pulse_cnt, 32);
        check_ramp(0, 0, 1);
        check_ramp(16, 64, 0);

        // Ties and extremes
        clear_got();
        fill(2);
        feed(0, 64);
        step(0, '0, '0, '0);
        check("tie_pulses", pulse_cnt, 16);
        if (got1.size() > 0) begin
            check("tie_255_0", got1[0], 255);
            check("tie_zero", got2[0], 0);
        end
        foreach (got3[i]) check("tie_128", got3[i], 128);

        // Reset mid-frame, then fresh ramp
        fill(0);
        feed(0, 20);
        do_reset(3);
        clear_got();
        feed(0, 64);
        step(0, '0, '0, '0);
        check("post_rst_pulses", pulse_cnt, 16);
        check_ramp(0, 0, 1);

        // Random frames
        for (int f = 0; f < 100; f++) begin
            clear_got();
            fill(3);
            feed(40, 64);
            step(0, '0, '0, '0);
            check("rand_pulses", pulse_cnt, 16);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
